// File: rtl/tlc5957_pkg.sv
// Shared TLC5957 definitions: LAT-width command codes and word geometry.
// The transmit-side controller uses the same enum values as its LAT widths.
package tlc5957_pkg;

    localparam int TLC_SHIFT_W  = 48;
    localparam int TLC_GS_WORDS = 16;
    localparam int LAT_CNT_W    = 5;
    localparam logic [LAT_CNT_W-1:0] LAT_CNT_MAX = 5'd31;

    // Enum value equals the LAT width in SCLK strobes; CMD_UNKNOWN uses an unassigned width.
    typedef enum logic [3:0] {
        CMD_NONE      = 4'd0,
        CMD_WRTGS     = 4'd1,
        CMD_UNKNOWN   = 4'd2,
        CMD_LATGS     = 4'd3,
        CMD_WRTFC     = 4'd5,
        CMD_LINERESET = 4'd7,
        CMD_READFC    = 4'd11,
        CMD_TMGRST    = 4'd13,
        CMD_FCWRTEN   = 4'd15
    } cmd_t;

    function automatic cmd_t lat_width_to_cmd(input logic [LAT_CNT_W-1:0] width);
        cmd_t c;
        case (width)
            5'd0:    c = CMD_NONE;
            5'd1:    c = CMD_WRTGS;
            5'd3:    c = CMD_LATGS;
            5'd5:    c = CMD_WRTFC;
            5'd7:    c = CMD_LINERESET;
            5'd11:   c = CMD_READFC;
            5'd13:   c = CMD_TMGRST;
            5'd15:   c = CMD_FCWRTEN;
            default: c = CMD_UNKNOWN;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tlc5957_lat_decoder.sv
// LAT edge detection and strobe counting; emits a same-cycle decode event for
// the register file and a registered cmd/cmd_valid pair for observers.
module tlc5957_lat_decoder
    import tlc5957_pkg::*;
(
    input  logic clk,
    input  logic nrst,
    input  logic sclk,
    input  logic lat,
    output logic fire,
    output cmd_t fire_cmd,
    output logic cmd_valid,
    output cmd_t cmd
);

    logic                 lat_q_r;
    logic [LAT_CNT_W-1:0] lat_cnt_r;
    logic [LAT_CNT_W-1:0] cnt_s;
    logic                 fall_s;

    // Count including this cycle's strobe, then detect the LAT falling edge.
    always_comb begin
        cnt_s    = lat_cnt_r;
        fall_s   = 1'b0;
        fire     = 1'b0;
        fire_cmd = CMD_NONE;
        if (sclk && lat && (lat_cnt_r != LAT_CNT_MAX)) begin
            cnt_s = lat_cnt_r + 5'd1;
        end else begin
            cnt_s = lat_cnt_r;
        end
        fall_s   = lat_q_r && !lat;
        fire     = fall_s && (cnt_s != 5'd0);
        fire_cmd = lat_width_to_cmd(cnt_s);
    end

    // LAT history, strobe counter and registered command outputs.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            lat_q_r   <= 1'b0;
            lat_cnt_r <= 5'd0;
            cmd_valid <= 1'b0;
            cmd       <= CMD_NONE;
        end else begin
            lat_q_r   <= lat;
            lat_cnt_r <= fall_s ? 5'd0 : cnt_s;
            cmd_valid <= fire;
            if (fire) begin
                cmd <= fire_cmd;
            end else begin
                cmd <= cmd;
            end
        end
    end

endmodule

// File: rtl/tlc5957_rx_model.sv
// Receiver end of the TLC5957 SCLK/LAT/SIN/SOUT link: shift register, FC
// register, double-buffered GS banks, GCLK counter and sticky error flags.
module tlc5957_rx_model
    import tlc5957_pkg::*;
#(
    parameter int SHIFT_W  = TLC_SHIFT_W,
    parameter int GS_WORDS = TLC_GS_WORDS
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic                        driver_sclk,
    input  logic                        driver_gclk,
    input  logic                        driver_lat,
    input  logic                        driver_sin,
    output logic                        driver_sout,
    output logic [SHIFT_W-1:0]          fc_reg,
    input  logic [$clog2(GS_WORDS)-1:0] gs_rd_addr,
    output logic [SHIFT_W-1:0]          gs_rd_data,
    output logic [15:0]                 gclk_count,
    output logic                        cmd_valid,
    output logic [3:0]                  cmd,
    output logic                        err_unknown_cmd,
    output logic                        err_fc_locked,
    output logic                        err_gs_overflow
);

    localparam int ADDR_W = $clog2(GS_WORDS);
    localparam int PTR_W  = ADDR_W + 1;
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(GS_WORDS);

    logic [SHIFT_W-1:0] sreg_r;
    logic [SHIFT_W-1:0] fc_reg_r;
    logic [SHIFT_W-1:0] bank1_r [GS_WORDS];
    logic [SHIFT_W-1:0] bank2_r [GS_WORDS];
    logic [PTR_W-1:0]   ptr_r;
    logic [15:0]        gclk_count_r;
    logic               fc_wen_r;
    logic               err_unknown_r;
    logic               err_locked_r;
    logic               err_ovf_r;

    logic               fire_s;
    cmd_t               fire_cmd_s;
    cmd_t               cmd_s;
    logic [SHIFT_W-1:0] shifted_s;
    logic [SHIFT_W-1:0] sreg_next_s;
    logic               ptr_full_s;
    logic [ADDR_W-1:0]  ptr_idx_s;
    logic               gclk_clr_s;

    tlc5957_lat_decoder u_lat_decoder (
        .clk       (clk),
        .nrst      (nrst),
        .sclk      (driver_sclk),
        .lat       (driver_lat),
        .fire      (fire_s),
        .fire_cmd  (fire_cmd_s),
        .cmd_valid (cmd_valid),
        .cmd       (cmd_s)
    );

    // Commands act on the word including a strobe in the LAT-fall cycle.
    always_comb begin
        shifted_s   = sreg_r;
        sreg_next_s = sreg_r;
        gclk_clr_s  = 1'b0;
        if (driver_sclk) begin
            shifted_s = {sreg_r[SHIFT_W-2:0], driver_sin};
        end else begin
            shifted_s = sreg_r;
        end
        if (fire_s && (fire_cmd_s == CMD_READFC)) begin
            sreg_next_s = fc_reg_r;
        end else begin
            sreg_next_s = shifted_s;
        end
        if (fire_s && ((fire_cmd_s == CMD_LATGS) || (fire_cmd_s == CMD_LINERESET)
                       || (fire_cmd_s == CMD_TMGRST))) begin
            gclk_clr_s = 1'b1;
        end else begin
            gclk_clr_s = 1'b0;
        end
    end

    assign ptr_full_s = (ptr_r == PTR_FULL);
    assign ptr_idx_s  = ptr_r[ADDR_W-1:0];

    // Shift register, FC register, GS banks, slot pointer and sticky errors.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            sreg_r        <= '0;
            fc_reg_r      <= '0;
            ptr_r         <= '0;
            fc_wen_r      <= 1'b0;
            err_unknown_r <= 1'b0;
            err_locked_r  <= 1'b0;
            err_ovf_r     <= 1'b0;
            for (int i = 0; i < GS_WORDS; i++) begin
                bank1_r[i] <= '0;
                bank2_r[i] <= '0;
            end
        end else begin
            sreg_r <= sreg_next_s;
            if (fire_s) begin
                case (fire_cmd_s)
                    CMD_WRTGS: begin
                        if (ptr_full_s) begin
                            err_ovf_r <= 1'b1;
                        end else begin
                            bank1_r[ptr_idx_s] <= shifted_s;
                            ptr_r              <= ptr_r + PTR_W'(1);
                        end
                    end
                    CMD_LATGS, CMD_LINERESET: begin
                        if (ptr_full_s) begin
                            err_ovf_r <= 1'b1;
                        end else begin
                            err_ovf_r <= err_ovf_r;
                        end
                        // bank2 receives bank1 as it looks after this cycle's slot write.
                        for (int i = 0; i < GS_WORDS; i++) begin
                            if (!ptr_full_s && (ptr_idx_s == ADDR_W'(i))) begin
                                bank2_r[i] <= shifted_s;
                            end else begin
                                bank2_r[i] <= bank1_r[i];
                            end
                            if (fire_cmd_s == CMD_LINERESET) begin
                                bank1_r[i] <= '0;
                            end else if (!ptr_full_s && (ptr_idx_s == ADDR_W'(i))) begin
                                bank1_r[i] <= shifted_s;
                            end else begin
                                bank1_r[i] <= bank1_r[i];
                            end
                        end
                        ptr_r <= '0;
                    end
                    CMD_WRTFC: begin
                        if (fc_wen_r) begin
                            fc_reg_r <= shifted_s;
                        end else begin
                            err_locked_r <= 1'b1;
                        end
                        fc_wen_r <= 1'b0;
                    end
                    CMD_FCWRTEN: begin
                        fc_wen_r <= 1'b1;
                    end
                    CMD_UNKNOWN: begin
                        err_unknown_r <= 1'b1;
                    end
                    default: begin
                        fc_wen_r <= fc_wen_r;
                    end
                endcase
            end
        end
    end

    // GCLK strobe counter; a clearing command wins over a same-cycle strobe.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            gclk_count_r <= 16'd0;
        end else if (gclk_clr_s) begin
            gclk_count_r <= 16'd0;
        end else if (driver_gclk && (gclk_count_r != 16'hFFFF)) begin
            gclk_count_r <= gclk_count_r + 16'd1;
        end else begin
            gclk_count_r <= gclk_count_r;
        end
    end

    assign driver_sout     = sreg_r[SHIFT_W-1];
    assign fc_reg          = fc_reg_r;
    assign gs_rd_data      = bank2_r[gs_rd_addr];
    assign gclk_count      = gclk_count_r;
    assign cmd             = cmd_s;
    assign err_unknown_cmd = err_unknown_r;
    assign err_fc_locked   = err_locked_r;
    assign err_gs_overflow = err_ovf_r;

endmodule

// File: tb/tb_tlc5957_rx_model.sv
// Directed bench for tlc5957_rx_model: FC write/lock/readback, GS banking,
// overflow, unknown/zero-width LAT, GCLK counting and mid-command reset.
module tb_tlc5957_rx_model;
    import tlc5957_pkg::*;

    logic        clk;
    logic        nrst;
    logic        driver_sclk;
    logic        driver_gclk;
    logic        driver_lat;
    logic        driver_sin;
    logic        driver_sout;
    logic [47:0] fc_reg;
    logic [3:0]  gs_rd_addr;
    logic [47:0] gs_rd_data;
    logic [15:0] gclk_count;
    logic        cmd_valid;
    logic [3:0]  cmd;
    logic        err_unknown_cmd;
    logic        err_fc_locked;
    logic        err_gs_overflow;

    int checks = 0;
    int errors = 0;

    localparam logic [47:0] FC_WORD = 48'hA5A5_0F0F_1234;

    tlc5957_rx_model dut (
        .clk             (clk),
        .nrst            (nrst),
        .driver_sclk     (driver_sclk),
        .driver_gclk     (driver_gclk),
        .driver_lat      (driver_lat),
        .driver_sin      (driver_sin),
        .driver_sout     (driver_sout),
        .fc_reg          (fc_reg),
        .gs_rd_addr      (gs_rd_addr),
        .gs_rd_data      (gs_rd_data),
        .gclk_count      (gclk_count),
        .cmd_valid       (cmd_valid),
        .cmd             (cmd),
        .err_unknown_cmd (err_unknown_cmd),
        .err_fc_locked   (err_fc_locked),
        .err_gs_overflow (err_gs_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle: inputs applied at negedge, outputs observed 1 unit after posedge.
    task automatic tick(input logic s, input logic d, input logic l, input logic g);
        @(negedge clk);
        driver_sclk = s;
        driver_sin  = d;
        driver_lat  = l;
        driver_gclk = g;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // 48 bits MSB-first with LAT high over the last 'tail' strobes, then LAT low.
    task automatic shift_word(input logic [47:0] w, input int tail);
        for (int i = 0; i < 48; i++) begin
            tick(1'b1, w[47-i], (i >= 48 - tail), 1'b0);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic lat_cmd(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b1, 1'b0, 1'b1, 1'b0);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [47:0] got;
        nrst        = 1'b0;
        driver_sclk = 1'b0;
        driver_gclk = 1'b0;
        driver_lat  = 1'b0;
        driver_sin  = 1'b0;
        gs_rd_addr  = 4'd0;
        got         = 48'd0;
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
        nrst = 1'b1;

        chk("rst_sout", 48'(driver_sout), 48'd0);
        chk("rst_fc", fc_reg, 48'd0);
        chk("rst_valid", 48'(cmd_valid), 48'd0);
        chk("rst_gclk", 48'(gclk_count), 48'd0);
        chk("rst_errs", 48'({err_unknown_cmd, err_fc_locked, err_gs_overflow}), 48'd0);
        chk("rst_gs", gs_rd_data, 48'd0);

        // FCWRTEN then WRTFC of FC_WORD
        lat_cmd(15);
        chk("fcwrten_valid", 48'(cmd_valid), 48'd1);
        chk("fcwrten_cmd", 48'(cmd), 48'(CMD_FCWRTEN));
        shift_word(FC_WORD, 5);
        chk("wrtfc_valid", 48'(cmd_valid), 48'd1);
        chk("wrtfc_cmd", 48'(cmd), 48'(CMD_WRTFC));
        chk("wrtfc_fc", fc_reg, FC_WORD);
        chk("wrtfc_nolock", 48'(err_fc_locked), 48'd0);

        // WRTFC with write-enable already consumed
        shift_word(48'h1111_2222_3333, 5);
        chk("locked_valid", 48'(cmd_valid), 48'd1);
        chk("locked_cmd", 48'(cmd), 48'(CMD_WRTFC));
        chk("locked_fc", fc_reg, FC_WORD);
        chk("locked_err", 48'(err_fc_locked), 48'd1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("locked_pulse_once", 48'(cmd_valid), 48'd0);

        // READFC and serial readback
        lat_cmd(11);
        chk("readfc_cmd", 48'(cmd), 48'(CMD_READFC));
        chk("readfc_msb", 48'(driver_sout), 48'd1);
        repeat (5) tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("readfc_idle_msb", 48'(driver_sout), 48'd1);
        for (int i = 0; i < 48; i++) begin
            got[47-i] = driver_sout;
            tick(1'b1, 1'b0, 1'b0, 1'b0);
        end
        chk("readback_word", got, FC_WORD);

        // GS: slots 0..14 by WRTGS, slot 15 with LATGS
        for (int k = 0; k < 15; k++) begin
            shift_word(48'(k), 1);
        end
        chk("wrtgs_cmd", 48'(cmd), 48'(CMD_WRTGS));
        chk("bank2_before_latgs", gs_rd_data, 48'd0);
        repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk("gclk_count3", 48'(gclk_count), 48'd3);
        shift_word(48'd15, 3);
        chk("latgs_cmd", 48'(cmd), 48'(CMD_LATGS));
        chk("latgs_gclk_clr", 48'(gclk_count), 48'd0);
        for (int k = 0; k < 16; k++) begin
            gs_rd_addr = 4'(k);
            #1;
            chk($sformatf("gs_word%0d", k), gs_rd_data, 48'(k));
        end

        // Overflow: 16 writes fill the bank, the 17th is dropped
        for (int k = 0; k < 16; k++) begin
            shift_word(48'(k + 100), 1);
        end
        chk("ovf_not_yet", 48'(err_gs_overflow), 48'd0);
        shift_word(48'hDEAD, 1);
        chk("ovf_set", 48'(err_gs_overflow), 48'd1);
        gs_rd_addr = 4'd3;
        #1;
        chk("ovf_bank2_kept", gs_rd_data, 48'd3);

        // LINERESET with full pointer: copy then clear bank1
        lat_cmd(7);
        chk("linereset_cmd", 48'(cmd), 48'(CMD_LINERESET));
        gs_rd_addr = 4'd0;
        #1;
        chk("linereset_w0", gs_rd_data, 48'd100);
        gs_rd_addr = 4'd15;
        #1;
        chk("linereset_w15", gs_rd_data, 48'd115);
        shift_word(48'h55, 3);
        gs_rd_addr = 4'd0;
        #1;
        chk("after_lr_w0", gs_rd_data, 48'h55);
        gs_rd_addr = 4'd1;
        #1;
        chk("after_lr_w1_cleared", gs_rd_data, 48'd0);

        // Unknown width and zero-width LAT
        lat_cmd(9);
        chk("unknown_valid", 48'(cmd_valid), 48'd1);
        chk("unknown_cmd", 48'(cmd), 48'(CMD_UNKNOWN));
        chk("unknown_err", 48'(err_unknown_cmd), 48'd1);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("zero_width_ignored", 48'(cmd_valid), 48'd0);

        // GCLK count then TMGRST
        repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk("gclk_count4", 48'(gclk_count), 48'd4);
        lat_cmd(13);
        chk("tmgrst_cmd", 48'(cmd), 48'(CMD_TMGRST));
        chk("tmgrst_clr", 48'(gclk_count), 48'd0);

        // Reset in the middle of a LAT transfer
        repeat (10) tick(1'b1, 1'b1, 1'b1, 1'b0);
        nrst = 1'b0;
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        nrst = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst_no_valid", 48'(cmd_valid), 48'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst_no_valid2", 48'(cmd_valid), 48'd0);
        chk("midrst_fc", fc_reg, 48'd0);
        chk("midrst_sout", 48'(driver_sout), 48'd0);
        chk("midrst_errs", 48'({err_unknown_cmd, err_fc_locked, err_gs_overflow}), 48'd0);
        chk("midrst_gs", gs_rd_data, 48'd0);
        chk("midrst_gclk", 48'(gclk_count), 48'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlc5957_rx_model.md
# tlc5957_rx_model

Single-channel receiver for the TLC5957 serial interface: the driver-side end of the SCLK/LAT/SIN/SOUT link that `driver_controller` transmits on. It decodes LAT-width commands and maintains the 48-bit common shift register, the function-control (FC) register and both GS banks. It drives SOUT for READFC readback. It serves as the bench target for the controller and as an on-chip loopback for bring-up.

## Interface
- `SHIFT_W`, 48: common shift register / FC / GS word width.
- `GS_WORDS`, 16: GS bank depth (WRTGS slots per LATGS).
- `clk` in 1: system clock; all sampling on its rising edge.
- `nrst` in 1: reset, synchronous, active-low.
- `driver_sclk` in 1: SCLK strobe; 1 = one SCLK rising edge this cycle.
- `driver_gclk` in 1: GCLK strobe; 1 = one GCLK edge this cycle.
- `driver_lat` in 1: LAT level, sampled each cycle.
- `driver_sin` in 1: serial data, valid when `driver_sclk`=1.
- `driver_sout` out 1: shift register MSB.
- `fc_reg` out SHIFT_W: current FC register.
- `gs_rd_addr` in $clog2(GS_WORDS): bank-2 read address.
- `gs_rd_data` out SHIFT_W: bank-2 word, combinational from address.
- `gclk_count` out 16: GCLK strobes since last LATGS, saturating.
- `cmd_valid` out 1: one-cycle pulse when a command is decoded.
- `cmd` out 4: decoded command code (tlc5957_pkg enum), valid with `cmd_valid`.
- `err_unknown_cmd` out 1: sticky; undefined LAT width seen.
- `err_fc_locked` out 1: sticky; WRTFC without preceding FCWRTEN.
- `err_gs_overflow` out 1: sticky; WRTGS with slot pointer = GS_WORDS.

## Operation
- Shift: each cycle with `driver_sclk`=1: `sreg <= {sreg[SHIFT_W-2:0], driver_sin}`, regardless of LAT.
- LAT counter `lat_cnt` (5 b, saturates at 31): increments on `driver_sclk`=1 while `driver_lat`=1; clears when the command is decoded.
- Decode on LAT falling edge (`lat_q`=1, `driver_lat`=0), using the count including any strobe that same cycle:
  - 1 WRTGS: `bank1[ptr] <= sreg`, `ptr++`.
  - 3 LATGS: `bank1[ptr] <= sreg`, then whole bank1 (with that write) copied to bank2, `ptr <= 0`, `gclk_count <= 0`.
  - 5 WRTFC: if `fc_wen`, then `fc_reg <= sreg`; otherwise set `err_fc_locked`, no update. `fc_wen <= 0` either way.
  - 7 LINERESET: LATGS actions; `bank1` cleared after the copy.
  - 11 READFC: `sreg <= fc_reg`.
  - 13 TMGRST: `gclk_count <= 0`.
  - 15 FCWRTEN: `fc_wen <= 1`.
  - 0: no command, no pulse, no error.
  - any other value: `err_unknown_cmd`, `cmd_valid` pulses with `cmd`=CMD_UNKNOWN.
- The shifted word used by a command includes the bits clocked while LAT was high (latch at end of transfer).
- WRTGS or LATGS with `ptr`=GS_WORDS: set `err_gs_overflow`, drop the write. `ptr` holds, except LATGS/LINERESET reset it.
- `driver_sout` = `sreg[SHIFT_W-1]`. READFC readback: MSB is visible the cycle after decode, and the next bit follows each SCLK strobe.
- `gclk_count` increments on `driver_gclk`=1 and saturates at 0xFFFF. A same-cycle LATGS/TMGRST clear takes priority.

## Timing
- Reset values: `sreg`, `fc_reg`, banks, `ptr`, `lat_cnt`, `gclk_count`, `fc_wen`, error flags, `cmd_valid` are all 0, so `driver_sout`=0.
- Decode latency: `cmd_valid`, register updates, and `fc_reg`/bank changes become visible 1 cycle after the cycle LAT is sampled low.
- SCLK strobe in the LAT-fall cycle: its bit is shifted first, and that shifted `sreg` is the value used by the command.
- LAT rising and falling in consecutive cycles without a strobe produces count 0 and is ignored.
- `nrst` low mid-command discards the partial `lat_cnt` and clears all state. Sticky errors clear only on reset.

## Structure
- `tlc5957_pkg`: `cmd_t` enum (WRTGS=1, LATGS=3, WRTFC=5, LINERESET=7, READFC=11, TMGRST=13, FCWRTEN=15, CMD_UNKNOWN), width constants. Shared with `driver_controller` for its LAT widths.
- Sub-module `tlc5957_lat_decoder`: LAT edge detection, `lat_cnt`, and `cmd`/`cmd_valid` generation. The top level holds the registers and banks.

## Test plan
- Config write: LAT high 15 strobes, then 48 bits of 0xA5A5_0F0F_1234 with LAT high over the last 5 → `fc_reg`=0xA5A50F0F1234, `err_fc_locked`=0.
- WRTFC without FCWRTEN → `fc_reg` unchanged, `err_fc_locked`=1, `cmd`=WRTFC pulsed once.
- Readback: after config write, READFC (11 strobes), then 5 idle cycles, then 48 strobes → `driver_sout` sequence equals 0xA5A50F0F1234 MSB-first.
- GS: 15× (48 bits = slot index, WRTGS), then word 15 plus LATGS → `gs_rd_data` at address k = k for k=0..15; `gclk_count`=0.
- Overflow/unknown: 17 writes without LATGS → `err_gs_overflow`=1. A 9-strobe LAT → `err_unknown_cmd`=1.
- Reset mid-LAT: 10 strobes with LAT high, `nrst`=0 one cycle, LAT low → no `cmd_valid`, all outputs 0.
